// File: rtl/regfile_ctrl_if.sv
// regfile_ctrl_if: command/response handshake bundle for regfile_ctrl.
//   master modport: command initiator / response consumer (datapath or bench).
//   slave  modport: the controller itself.
// Signals:
//   cmd_valid/cmd_ready, cmd_op[1:0], cmd_rd[AW], cmd_rs[AW], cmd_data[DW]
//   rsp_valid/rsp_ready, rsp_data[DW], rsp_err
interface regfile_ctrl_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 3
) ();
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_rd;
    logic [AW-1:0] cmd_rs;
    logic [DW-1:0] cmd_data;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: sole initiator of the 8x16 register file. Accepts one command
// (WRITE/READ/COPY/SWAP) at a time and returns exactly one response.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   bus (slave)         command/response handshake (regfile_ctrl_if)
//   rf_data_in          to regfile data_in
//   rf_writenum         to regfile writenum
//   rf_write            to regfile write
//   rf_readnum          to regfile readnum
//   rf_data_out         from regfile data_out (combinational read)
// Build option: REGFILE_CTRL_SWAP_EN enables op 11 (SWAP); otherwise op 11
// returns rsp_err=1 with rsp_data=0 and touches nothing.
module regfile_ctrl #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_ctrl_if.slave bus,
    output logic [DW-1:0] rf_data_in,
    output logic [AW-1:0] rf_writenum,
    output logic          rf_write,
    output logic [AW-1:0] rf_readnum,
    input  logic [DW-1:0] rf_data_out
);
    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_SWAP  = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
`ifdef REGFILE_CTRL_SWAP_EN
        RD1  = 3'd2,
`endif
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_op, w_op_nxt;
    logic [AW-1:0] r_rd, w_rd_nxt;
    logic [AW-1:0] r_rs, w_rs_nxt;
    logic [DW-1:0] r_data, w_data_nxt;
    logic [DW-1:0] r_tmp, w_tmp_nxt;

    logic          r_cmd_ready, w_cmd_ready_nxt;
    logic          r_rsp_valid, w_rsp_valid_nxt;
    logic [DW-1:0] r_rsp_data, w_rsp_data_nxt;
    logic          r_rsp_err, w_rsp_err_nxt;
    logic          r_rf_write, w_rf_write_nxt;
    logic [AW-1:0] r_rf_writenum, w_rf_writenum_nxt;
    logic [AW-1:0] r_rf_readnum, w_rf_readnum_nxt;
    logic [DW-1:0] r_rf_data_in, w_rf_data_in_nxt;
    logic          w_err;

    // State, latched command and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_op          <= 2'b00;
            r_rd          <= AW'(0);
            r_rs          <= AW'(0);
            r_data        <= DW'(0);
            r_tmp         <= DW'(0);
            r_cmd_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= DW'(0);
            r_rsp_err     <= 1'b0;
            r_rf_write    <= 1'b0;
            r_rf_writenum <= AW'(0);
            r_rf_readnum  <= AW'(0);
            r_rf_data_in  <= DW'(0);
        end else begin
            r_state       <= w_state_nxt;
            r_op          <= w_op_nxt;
            r_rd          <= w_rd_nxt;
            r_rs          <= w_rs_nxt;
            r_data        <= w_data_nxt;
            r_tmp         <= w_tmp_nxt;
            r_cmd_ready   <= w_cmd_ready_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_data    <= w_rsp_data_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_rf_write    <= w_rf_write_nxt;
            r_rf_writenum <= w_rf_writenum_nxt;
            r_rf_readnum  <= w_rf_readnum_nxt;
            r_rf_data_in  <= w_rf_data_in_nxt;
        end
    end

    // Next state, then outputs derived from the state being entered
    always_comb begin
        w_state_nxt       = r_state;
        w_op_nxt          = r_op;
        w_rd_nxt          = r_rd;
        w_rs_nxt          = r_rs;
        w_data_nxt        = r_data;
        w_tmp_nxt         = r_tmp;
        w_rsp_data_nxt    = r_rsp_data;
        w_rsp_err_nxt     = r_rsp_err;
        w_rf_write_nxt    = 1'b0;
        w_rf_writenum_nxt = r_rf_writenum;
        w_rf_readnum_nxt  = r_rf_readnum;
        w_rf_data_in_nxt  = r_rf_data_in;
        w_err             = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    w_op_nxt   = bus.cmd_op;
                    w_rd_nxt   = bus.cmd_rd;
                    w_rs_nxt   = bus.cmd_rs;
                    w_data_nxt = bus.cmd_data;
                    case (bus.cmd_op)
                        OP_WRITE: w_state_nxt = WR;
                        OP_READ,
                        OP_COPY:  w_state_nxt = RD0;
`ifdef REGFILE_CTRL_SWAP_EN
                        default:  w_state_nxt = RD0;
`else
                        default:  w_state_nxt = RESP;
`endif
                    endcase
                end
            end
            RD0: begin
                w_tmp_nxt = rf_data_out;
                if (r_op == OP_READ) begin
                    w_state_nxt = RESP;
`ifdef REGFILE_CTRL_SWAP_EN
                end else if (r_op == OP_SWAP) begin
                    w_state_nxt = RD1;
`endif
                end else begin
                    w_state_nxt = WR;
                end
            end
`ifdef REGFILE_CTRL_SWAP_EN
            RD1:     w_state_nxt = WR;
`endif
            WR:      w_state_nxt = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

`ifndef REGFILE_CTRL_SWAP_EN
        w_err = (w_op_nxt == OP_SWAP);
`endif

        case (w_state_nxt)
            RD0: begin
                // SWAP reads rd first so its old value can be returned
                w_rf_readnum_nxt = (w_op_nxt == OP_SWAP) ? w_rd_nxt : w_rs_nxt;
            end
`ifdef REGFILE_CTRL_SWAP_EN
            RD1: begin
                w_rf_readnum_nxt  = w_rs_nxt;
                w_rf_write_nxt    = 1'b1;
                w_rf_writenum_nxt = w_rd_nxt;
            end
`endif
            WR: begin
                w_rf_write_nxt    = 1'b1;
                w_rf_writenum_nxt = (w_op_nxt == OP_SWAP) ? w_rs_nxt : w_rd_nxt;
                w_rf_data_in_nxt  = (w_op_nxt == OP_WRITE) ? w_data_nxt : w_tmp_nxt;
            end
            RESP: begin
                w_rsp_err_nxt  = w_err;
                w_rsp_data_nxt = w_err ? DW'(0)
                               : ((w_op_nxt == OP_WRITE) ? w_data_nxt : w_tmp_nxt);
            end
            default: ;
        endcase

        w_cmd_ready_nxt = (w_state_nxt == IDLE);
        w_rsp_valid_nxt = (w_state_nxt == RESP);
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign rf_write      = r_rf_write;
    assign rf_writenum   = r_rf_writenum;
    assign rf_readnum    = r_rf_readnum;

`ifdef REGFILE_CTRL_SWAP_EN
    // In RD1 the old rs value is forwarded straight from the read port into rd
    assign rf_data_in = (r_state == RD1) ? rf_data_out : r_rf_data_in;
`else
    assign rf_data_in = r_rf_data_in;
`endif

endmodule

// File: tb/tb_regfile_ctrl.sv
module tb_regfile_ctrl;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          init_n;
    logic [DW-1:0] rf_data_in;
    logic [DW-1:0] rf_data_out;
    logic [AW-1:0] rf_writenum;
    logic [AW-1:0] rf_readnum;
    logic          rf_write;

    int checks = 0;
    int passes = 0;
    int wr_cnt = 0;
    logic [AW-1:0] last_wn = '0;

    typedef struct packed {
        logic [15:0] d;
        logic        e;
        logic [7:0]  lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    regfile_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    regfile_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .rf_data_in  (rf_data_in),
        .rf_writenum (rf_writenum),
        .rf_write    (rf_write),
        .rf_readnum  (rf_readnum),
        .rf_data_out (rf_data_out)
    );

    // Behavioural 8x16 register file: sync write, combinational read
    logic [DW-1:0] regs [8];
    always @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (rf_write) begin
            regs[rf_writenum] <= rf_data_in;
        end
    end
    assign rf_data_out = regs[rf_readnum];

    always @(posedge clk) begin
        if (rf_write) begin
            wr_cnt  <= wr_cnt + 1;
            last_wn <= rf_writenum;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive one command, push its expected response, wait for and score it
    task automatic issue(input string tag, input logic [1:0] op, input logic [2:0] rd,
                         input logic [2:0] rs, input logic [15:0] d, input logic rr,
                         input logic [15:0] ed, input logic ee, input int el);
        exp_t e;
        int   n;
        int   lat;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_rd    = rd;
        bus.cmd_rs    = rs;
        bus.cmd_data  = d;
        bus.rsp_ready = rr;
        sb.push_back('{d: ed, e: ee, lat: 8'(el)});
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".accept"}, 32'(n < 20), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        chk({tag, ".lat"},  32'(lat), 32'(e.lat));
        chk({tag, ".data"}, 32'(bus.rsp_data), 32'(e.d));
        chk({tag, ".err"},  32'(bus.rsp_err), 32'(e.e));
    endtask

    task automatic finish_rsp(input string tag);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".rsp_done"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, ".ready_back"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  w0;
        logic seen;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_rd    = '0;
        bus.cmd_rs    = '0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b1;
        rst_n  = 1'b1;
        init_n = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst.rsp_data",  32'(bus.rsp_data), 32'd0);
        chk("rst.rsp_err",   32'(bus.rsp_err), 32'd0);
        chk("rst.rf_write",  32'(rf_write), 32'd0);
        chk("rst.rf_wn",     32'(rf_writenum), 32'd0);
        chk("rst.rf_rn",     32'(rf_readnum), 32'd0);
        chk("rst.rf_din",    32'(rf_data_in), 32'd0);
        init_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // WRITE then READ
        w0 = wr_cnt;
        issue("wr3", 2'b00, 3'd3, 3'd0, 16'hBEEF, 1'b1, 16'hBEEF, 1'b0, 2);
        finish_rsp("wr3");
        chk("wr3.pulses", 32'(wr_cnt - w0), 32'd1);
        chk("wr3.wnum",   32'(last_wn), 32'd3);
        issue("rd3", 2'b01, 3'd0, 3'd3, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 2);
        finish_rsp("rd3");

        // COPY r3 -> r5
        issue("cp53", 2'b10, 3'd5, 3'd3, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 3);
        finish_rsp("cp53");
        issue("rd5", 2'b01, 3'd0, 3'd5, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 2);
        finish_rsp("rd5");

        // SWAP r1 <-> r2, and rd == rs
        issue("wr1", 2'b00, 3'd1, 3'd0, 16'h1111, 1'b1, 16'h1111, 1'b0, 2);
        finish_rsp("wr1");
        issue("wr2", 2'b00, 3'd2, 3'd0, 16'h2222, 1'b1, 16'h2222, 1'b0, 2);
        finish_rsp("wr2");
        issue("wr6", 2'b00, 3'd6, 3'd0, 16'h6666, 1'b1, 16'h6666, 1'b0, 2);
        finish_rsp("wr6");
`ifdef REGFILE_CTRL_SWAP_EN
        issue("sw12", 2'b11, 3'd1, 3'd2, 16'h0000, 1'b1, 16'h1111, 1'b0, 4);
        finish_rsp("sw12");
        issue("rd1", 2'b01, 3'd0, 3'd1, 16'h0000, 1'b1, 16'h2222, 1'b0, 2);
        finish_rsp("rd1");
        issue("rd2", 2'b01, 3'd0, 3'd2, 16'h0000, 1'b1, 16'h1111, 1'b0, 2);
        finish_rsp("rd2");
        issue("sw66", 2'b11, 3'd6, 3'd6, 16'h0000, 1'b1, 16'h6666, 1'b0, 4);
        finish_rsp("sw66");
`else
        w0 = wr_cnt;
        issue("sw12", 2'b11, 3'd1, 3'd2, 16'h0000, 1'b1, 16'h0000, 1'b1, 1);
        finish_rsp("sw12");
        chk("sw12.nowrite", 32'(wr_cnt - w0), 32'd0);
        issue("rd1", 2'b01, 3'd0, 3'd1, 16'h0000, 1'b1, 16'h1111, 1'b0, 2);
        finish_rsp("rd1");
        issue("rd2", 2'b01, 3'd0, 3'd2, 16'h0000, 1'b1, 16'h2222, 1'b0, 2);
        finish_rsp("rd2");
        issue("sw66", 2'b11, 3'd6, 3'd6, 16'h0000, 1'b1, 16'h0000, 1'b1, 1);
        finish_rsp("sw66");
`endif
        issue("rd6", 2'b01, 3'd0, 3'd6, 16'h0000, 1'b1, 16'h6666, 1'b0, 2);
        finish_rsp("rd6");

        // Back-pressure on the response; a stray command must be ignored
        w0 = wr_cnt;
        issue("hold", 2'b01, 3'd0, 3'd3, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 2);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = 2'b00;
                bus.cmd_rd    = 3'd0;
                bus.cmd_data  = 16'h5555;
            end
            if (i == 2) bus.cmd_valid = 1'b0;
            @(posedge clk);
            #1;
            chk("hold.valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold.data",  32'(bus.rsp_data), 32'hBEEF);
            chk("hold.cready", 32'(bus.cmd_ready), 32'd0);
        end
        finish_rsp("hold");
        chk("hold.nowrite", 32'(wr_cnt - w0), 32'd0);
        issue("rd0", 2'b01, 3'd0, 3'd0, 16'h0000, 1'b1, 16'h0000, 1'b0, 2);
        finish_rsp("rd0");

        // Reset while a WRITE sits in WR: no commit, no response
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        bus.cmd_rd    = 3'd4;
        bus.cmd_data  = 16'hAAAA;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        chk("abort.in_wr", 32'(rf_write), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort.rf_write",  32'(rf_write), 32'd0);
        chk("abort.rf_wn",     32'(rf_writenum), 32'd0);
        chk("abort.rf_din",    32'(rf_data_in), 32'd0);
        chk("abort.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort.cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) seen = 1'b1;
        end
        chk("abort.no_rsp", 32'(seen), 32'd0);
        issue("rd4", 2'b01, 3'd0, 3'd4, 16'h0000, 1'b1, 16'h0000, 1'b0, 2);
        finish_rsp("rd4");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/regfile_ctrl.md
# regfile_ctrl

Command-driven access controller that sits in front of the 8×16-bit `regfile` and acts as its sole initiator. It accepts one command at a time over a valid/ready interface and sequences the register file's write port (`writenum`, `write`, `data_in`) and read port (`readnum`, `data_out`). It returns exactly one response per command over a second valid/ready interface. Supported operations are write, read, copy and (optionally) swap; it is the block the datapath/testbench uses instead of poking the register file directly.

## Interface
Parameters:
- `DW`, 16, data width; must match the register file.
- `AW`, 3, register index width (8 registers).

Ports:
- `clk` input 1: single clock; all state updates on posedge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: controller can accept; high only in IDLE.
- `cmd_op` input 2: 00 WRITE, 01 READ, 10 COPY, 11 SWAP.
- `cmd_rd` input AW: destination register index.
- `cmd_rs` input AW: source register index.
- `cmd_data` input DW: write data (WRITE only).
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: response consumed.
- `rsp_data` output DW: result data.
- `rsp_err` output 1: unsupported op.
- `rf_data_in` output DW: to register file `data_in`.
- `rf_writenum` output AW: to register file `writenum`.
- `rf_write` output 1: to register file `write`.
- `rf_readnum` output AW: to register file `readnum`.
- `rf_data_out` input DW: from register file `data_out` (combinational read).

## Operation
- Command accepted on a posedge where `cmd_valid & cmd_ready`. On acceptance, op, rd, rs and data are latched into internal registers. Inputs are ignored at all other times.
- States: IDLE, RD0, RD1, WR, RESP.
  - WRITE: IDLE→WR→RESP.
  - READ: IDLE→RD0→RESP.
  - COPY: IDLE→RD0→WR→RESP.
  - SWAP: IDLE→RD0→RD1→WR→RESP.
  - Error: IDLE→RESP.
- RD0:
  - `rf_readnum` = rs for READ and COPY; `rf_readnum` = rd for SWAP.
  - `rf_data_out` is captured into `tmp` at the exiting edge.
- RD1 (SWAP only):
  - `rf_readnum` = rs.
  - `rf_write` = 1, `rf_writenum` = rd, `rf_data_in` = `rf_data_out` (the old rs value is written into rd).
- WR:
  - `rf_write` = 1.
  - WRITE: `rf_writenum` = rd, `rf_data_in` = latched data.
  - COPY: `rf_writenum` = rd, `rf_data_in` = `tmp`.
  - SWAP: `rf_writenum` = rs, `rf_data_in` = `tmp`.
- `rf_write` is 0 in every other state. When idle, `rf_*` outputs hold their last values; only `rf_write` is forced to 0.
- RESP:
  - `rsp_valid` = 1.
  - `rsp_data`: the written data for WRITE; `tmp` for READ, COPY and SWAP (SWAP returns the old rd value).
  - `rsp_err` = 0, except 1 for an unsupported op, with `rsp_data` = 0.
  - Outputs held stable until `rsp_ready`. The handshake edge returns the FSM to IDLE.
- One command outstanding. No overlap between response and next command.
- rd == rs:
  - COPY writes the register with its own value.
  - SWAP leaves the register unchanged.
  - Neither is an error.

## Timing
- Latency from the accepting edge to `rsp_valid` high, with `rsp_ready` held high: WRITE 2, READ 2, COPY 3, SWAP 4, error 1 cycle.
- `cmd_ready` rises the cycle after the response handshake. Back-to-back WRITEs take 3 cycles each.
- A register-file write commits at the edge leaving WR or RD1. Any later command observes it.
- Reset (`rst_n` low) has immediate asynchronous effect:
  - FSM returns to IDLE; `tmp` and latched command registers are cleared.
  - Outputs: `cmd_ready` = 1, `rsp_valid` = 0, `rsp_data` = 0, `rsp_err` = 0, `rf_write` = 0, `rf_writenum` = 0, `rf_readnum` = 0, `rf_data_in` = 0.
- Reset mid-operation aborts the command: no further write and no response. A SWAP reset after RD1 leaves rd updated and rs unchanged (accepted).
- `cmd_valid` while not ready is ignored; the command must be held by the sender.

## Configuration
- `REGFILE_CTRL_SWAP_EN` defined: op 11 executes SWAP as above.
- Not defined:
  - op 11 is accepted, goes IDLE→RESP, and returns `rsp_err` = 1, `rsp_data` = 0.
  - No register-file write occurs and RD1 is not implemented.

## Test plan
- Reset with `rst_n` = 0 mid-cycle → all outputs at reset values immediately; `cmd_ready` = 1 after release.
- WRITE rd=3, data=16'hBEEF, then READ rs=3 → write response `rsp_data` = BEEF at 2 cycles; read response BEEF at 2 cycles; `rf_write` pulses exactly one cycle with `rf_writenum` = 3.
- COPY rd=5, rs=3 (r3=BEEF), then READ 5 → COPY response BEEF at 3 cycles; READ 5 returns BEEF.
- SWAP rd=1 (=0x1111), rs=2 (=0x2222) with macro defined → response 0x1111 at 4 cycles; then READ 1 returns 0x2222 and READ 2 returns 0x1111. Without the macro → response at 1 cycle with `rsp_err` = 1 and registers unchanged.
- Hold `rsp_ready` = 0 for 5 cycles after READ → `rsp_valid`/`rsp_data` stable; `cmd_ready` = 0 throughout; a `cmd_valid` pulse is ignored.
- Assert reset during WR of a WRITE (data 0xAAAA to r4, r4 = 0x0000 beforehand) before the clock edge → r4 stays 0x0000; no response emitted.
